// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results (buffered in a small FIFO) and load returns onto
// the single regfile write port, and forwards pending/in-flight values to operand reads.
module wb_stage #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            reg_write,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_fwd_hit,
    output logic [XLEN-1:0] rs1_fwd_data,
    output logic            rs2_fwd_hit,
    output logic [XLEN-1:0] rs2_fwd_data,
    output logic            fifo_full
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } res_t;

    res_t            mem_q [FIFO_DEPTH];
    res_t            mem_d [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            reg_write_q, reg_write_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;

    logic full, empty, enq, deq, issue_v;
    res_t head, alu_res, lsu_res, issue;

    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign fifo_full = full;
    assign alu_ready = !full;
    assign lsu_ready = !full;
    assign head      = mem_q[rd_ptr_q];
    assign alu_res   = {alu_rd, alu_data};
    assign lsu_res   = {lsu_rd, lsu_data};

    assign reg_write = reg_write_q;
    assign rd_addr   = rd_addr_q;
    assign rd_data   = rd_data_q;

    // A full FIFO always drains first; otherwise loads win, and an ALU result arriving
    // at an empty FIFO with no load passes straight through without being stored.
    always_comb begin
        enq     = 1'b0;
        deq     = 1'b0;
        issue_v = 1'b0;
        issue   = head;
        if (full) begin
            deq     = 1'b1;
            issue_v = 1'b1;
        end else if (lsu_valid) begin
            issue   = lsu_res;
            issue_v = 1'b1;
            enq     = alu_valid;
        end else if (!empty) begin
            deq     = 1'b1;
            issue_v = 1'b1;
            enq     = alu_valid;
        end else if (alu_valid) begin
            issue   = alu_res;
            issue_v = 1'b1;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            mem_d[wr_ptr_q] = alu_res;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
        if (enq && !deq)      count_d = count_q + 1'b1;
        else if (deq && !enq) count_d = count_q - 1'b1;

        reg_write_d = issue_v && (issue.rd != 5'd0);
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        if (reg_write_d) begin
            rd_addr_d = issue.rd;
            rd_data_d = issue.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            reg_write_q <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            reg_write_q <= reg_write_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Payload storage needs no reset: validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    logic [1:0][4:0]      rs;
    logic [1:0]           hit;
    logic [1:0][XLEN-1:0] fdata;

    assign rs = {rs2_addr, rs1_addr};

    // Later (younger) matches overwrite earlier ones, so the scan order sets priority.
    always_comb begin
        hit   = '0;
        fdata = '0;
        for (int p = 0; p < 2; p++) begin
            if (reg_write_q && rd_addr_q == rs[p]) begin
                hit[p]   = 1'b1;
                fdata[p] = rd_data_q;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (CW'(i) < count_q && mem_q[rd_ptr_q + PW'(i)].rd == rs[p]) begin
                    hit[p]   = 1'b1;
                    fdata[p] = mem_q[rd_ptr_q + PW'(i)].data;
                end
            end
            if (rs[p] == 5'd0) begin
                hit[p]   = 1'b0;
                fdata[p] = '0;
            end
        end
    end

    assign rs1_fwd_hit  = hit[0];
    assign rs1_fwd_data = fdata[0];
    assign rs2_fwd_hit  = hit[1];
    assign rs2_fwd_data = fdata[1];
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a queue-based reference model.
module tb_wb_stage;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid = 1'b0, lsu_valid = 1'b0;
    logic            alu_ready, lsu_ready;
    logic [4:0]      alu_rd = '0, lsu_rd = '0, rs1_addr = '0, rs2_addr = '0;
    logic [XLEN-1:0] alu_data = '0, lsu_data = '0;
    logic            reg_write, rs1_fwd_hit, rs2_fwd_hit, fifo_full;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data, rs1_fwd_data, rs2_fwd_data;

    int checks = 0;
    int failures = 0;

    wb_stage #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_fwd_hit(rs1_fwd_hit), .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd_hit(rs2_fwd_hit), .rs2_fwd_data(rs2_fwd_data),
        .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    // Reference model: pending ALU results as a queue, plus the expected write port.
    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] d;
    } ent_t;
    ent_t            q[$];
    bit              m_we = 1'b0;
    logic [4:0]      m_addr = '0;
    logic [XLEN-1:0] m_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mfwd(input logic [4:0] rs, output bit h, output logic [XLEN-1:0] d);
        h = 1'b0;
        d = '0;
        if (rs == 5'd0) return;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].rd == rs) begin
                h = 1'b1;
                d = q[i].d;
                return;
            end
        if (m_we && m_addr == rs) begin
            h = 1'b1;
            d = m_data;
        end
    endfunction

    task automatic model_reset();
        q.delete();
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic model_step();
        ent_t is;
        bit   iv = 1'b0;
        ent_t a, l;
        a.rd = alu_rd; a.d = alu_data;
        l.rd = lsu_rd; l.d = lsu_data;
        is = a;
        if (q.size() == DEPTH) begin
            is = q.pop_front(); iv = 1'b1;
        end else if (lsu_valid) begin
            is = l; iv = 1'b1;
            if (alu_valid) q.push_back(a);
        end else if (q.size() > 0) begin
            is = q.pop_front(); iv = 1'b1;
            if (alu_valid) q.push_back(a);
        end else if (alu_valid) begin
            is = a; iv = 1'b1;
        end
        m_we = iv && is.rd != 5'd0;
        if (m_we) begin
            m_addr = is.rd;
            m_data = is.d;
        end
    endtask

    // Called just after a rising edge with inputs already driven for the coming edge.
    task automatic cycle();
        bit h;
        logic [XLEN-1:0] d;
        #1;
        chk("alu_ready", alu_ready, q.size() < DEPTH);
        chk("lsu_ready", lsu_ready, q.size() < DEPTH);
        chk("fifo_full", fifo_full, q.size() == DEPTH);
        mfwd(rs1_addr, h, d);
        chk("rs1_hit", rs1_fwd_hit, h);
        chk("rs1_data", rs1_fwd_data, d);
        mfwd(rs2_addr, h, d);
        chk("rs2_hit", rs2_fwd_hit, h);
        chk("rs2_data", rs2_fwd_data, d);
        @(posedge clk);
        model_step();
        #1;
        chk("reg_write", reg_write, m_we);
        if (m_we) begin
            chk("rd_addr", rd_addr, m_addr);
            chk("rd_data", rd_data, m_data);
        end
    endtask

    task automatic drive(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                         input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_reg_write", reg_write, 1'b0);
        chk("rst_rd_addr", rd_addr, 5'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_alu_ready", alu_ready, 1'b1);
        chk("rst_fifo_full", fifo_full, 1'b0);

        // ALU only: written the cycle after the handshake, then quiet
        drive(1'b1, 5'd1, 32'h12345678, 1'b0, 5'd0, '0);
        cycle();
        chk("alu1_we", reg_write, 1'b1);
        chk("alu1_addr", rd_addr, 5'd1);
        chk("alu1_data", rd_data, 32'h12345678);
        idle();
        cycle();
        chk("alu1_done", reg_write, 1'b0);

        // Same-cycle ALU and LSU: load first
        drive(1'b1, 5'd2, 32'h87654321, 1'b1, 5'd3, 32'hCAFEF00D);
        cycle();
        chk("both_lsu_addr", rd_addr, 5'd3);
        chk("both_lsu_data", rd_data, 32'hCAFEF00D);
        chk("both_alu_ready", alu_ready, 1'b1);
        idle();
        cycle();
        chk("both_alu_addr", rd_addr, 5'd2);
        chk("both_alu_data", rd_data, 32'h87654321);
        cycle();
        chk("both_drained", reg_write, 1'b0);

        // Sustained loads fill the FIFO
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd10, 32'h100);
        cycle();
        drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd11, 32'h101);
        cycle();
        chk("fill_full", fifo_full, 1'b1);
        chk("fill_alu_ready", alu_ready, 1'b0);
        chk("fill_lsu_ready", lsu_ready, 1'b0);
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd12, 32'h102);
        cycle();
        chk("fill_head_addr", rd_addr, 5'd4);
        cycle();
        chk("fill_lsu_resume", rd_addr, 5'd12);
        idle();
        repeat (3) cycle();

        // x0 destination
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, '0);
        rs1_addr = 5'd0;
        #1;
        chk("x0_accept", alu_ready, 1'b1);
        cycle();
        chk("x0_no_write", reg_write, 1'b0);
        chk("x0_fwd_hit", rs1_fwd_hit, 1'b0);
        chk("x0_fwd_data", rs1_fwd_data, 32'd0);

        // Forwarding priority: younger FIFO entry beats older and the output register
        drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd21, 32'h21);
        cycle();
        drive(1'b1, 5'd7, 32'hB, 1'b1, 5'd7, 32'hC);
        cycle();
        idle();
        rs2_addr = 5'd7;
        #1;
        chk("fwd_young_hit", rs2_fwd_hit, 1'b1);
        chk("fwd_young_data", rs2_fwd_data, 32'hB);
        chk("fwd_out_reg", rd_data, 32'hC);
        cycle();
        cycle();
        #1;
        chk("fwd_drain_out", rd_data, 32'hB);
        chk("fwd_drain_data", rs2_fwd_data, 32'hB);
        cycle();
        chk("fwd_none", rs2_fwd_hit, 1'b0);

        // Reset with pending entries and an active write
        drive(1'b1, 5'd8, 32'h8, 1'b1, 5'd9, 32'h9);
        cycle();
        drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
        cycle();
        idle();
        rs1_addr = 5'd8;
        chk("pre_rst_full", fifo_full, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_we", reg_write, 1'b0);
        chk("arst_addr", rd_addr, 5'd0);
        chk("arst_data", rd_data, 32'd0);
        chk("arst_full", fifo_full, 1'b0);
        chk("arst_fwd", rs1_fwd_hit, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) cycle();
        chk("post_rst_quiet", reg_write, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom);
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
